// File: rtl/uart_sched_pkg.sv
// Shared types and sizing helpers for the UART TX scheduler.
package uart_sched_pkg;

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, BUSY = 2'd2, GAP = 2'd3} sched_state_t;

   localparam int GAP_CYCLES_DEF     = 16;
   localparam int TIMEOUT_CYCLES_DEF = 4096;
   localparam int GAP_W = $clog2(GAP_CYCLES_DEF + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES_DEF);

   // Counter width for values 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sched_down_counter.sv
// Loadable down-counter with a zero flag; stops at zero.
module sched_down_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst_n)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (dec && !zero)
         count <= count - 1'b1;
   end

   assign zero = (count == '0);

endmodule

// File: rtl/uart_tx_scheduler.sv
// Drains the TX FIFO into the UART serialiser with CTS gating and an inter-frame gap.
// Optional BUSY watchdog enabled by defining UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_scheduler
   import uart_sched_pkg::*;
#(
   parameter int WIDTH          = 8,
   parameter int GAP_CYCLES     = 16,
   parameter int COUNT_WIDTH    = 16,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                   Clock,
   input  logic                   ResetN,
   input  logic                   Enable,
   input  logic                   ClearToSend,
   input  logic                   FifoEmpty,
   input  logic [WIDTH-1:0]       FifoReadData,
   output logic                   FifoRead,
   output logic [WIDTH-1:0]       TxData,
   output logic                   TxStart,
   input  logic                   TxDone,
   output logic                   Busy,
   output logic [COUNT_WIDTH-1:0] SentCount,
   input  logic                   ClearErr,
   output logic                   TimeoutErr
);

   localparam int CNT_GAP_W = cnt_w(GAP_CYCLES + 1);
   localparam logic [CNT_GAP_W-1:0] GAP_LOAD =
      (GAP_CYCLES > 0) ? CNT_GAP_W'(GAP_CYCLES - 1) : '0;

   sched_state_t state, state_nxt;
   logic launch, done_seen, gap_zero, timeout;

   assign launch    = (state == IDLE) && Enable && ClearToSend && !FifoEmpty;
   assign FifoRead  = launch;
   assign TxStart   = (state == LOAD);
   assign Busy      = (state != IDLE);
   // TxDone only matters while a frame is actually on the wire.
   assign done_seen = (state == BUSY) && TxDone;

   sched_down_counter #(.W(CNT_GAP_W)) u_gap (
      .clk      (Clock),
      .rst_n    (ResetN),
      .load     (done_seen),
      .load_val (GAP_LOAD),
      .dec      (state == GAP),
      .zero     (gap_zero)
   );

`ifdef UART_TX_SCHED_TIMEOUT_EN
   localparam int CNT_TMO_W = cnt_w(TIMEOUT_CYCLES);
   localparam logic [CNT_TMO_W-1:0] TMO_LIMIT = CNT_TMO_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_TMO_W-1:0] timer;
   logic                 err;

   // A TxDone landing on the limit cycle still completes the frame.
   assign timeout = (state == BUSY) && !TxDone && (timer == TMO_LIMIT);

   always_ff @(posedge Clock) begin
      if (!ResetN) begin
         timer <= '0;
         err   <= 1'b0;
      end else begin
         if (state == LOAD)
            timer <= '0;
         else if (state == BUSY)
            timer <= timer + 1'b1;
         if (timeout)
            err <= 1'b1;
         else if (ClearErr)
            err <= 1'b0;
      end
   end

   assign TimeoutErr = err;
`else
   logic unused_cfg;
   assign unused_cfg = ClearErr ^ (TIMEOUT_CYCLES > 0);
   assign timeout    = 1'b0;
   assign TimeoutErr = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (launch) state_nxt = LOAD;
         LOAD: state_nxt = BUSY;
         BUSY: begin
            if (TxDone)
               state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
            else if (timeout)
               state_nxt = IDLE;
         end
         GAP:  if (gap_zero) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!ResetN) begin
         state     <= IDLE;
         TxData    <= '0;
         SentCount <= '0;
      end else begin
         state <= state_nxt;
         if (launch)
            TxData <= FifoReadData;
         if (done_seen)
            SentCount <= SentCount + 1'b1;
      end
   end

endmodule
